xor_nn_sequencer: RTL and testbench

Sequencer for the XOR network forward pass. One internal multiply-accumulate and one external sigmoid unit are time-shared across all hidden neurons and then the output neuron. Weights and biases come from an external combinational weight ROM.
- Start: one pulse on `start`.
- Result: a registered 8-bit activation plus a one-cycle `done` pulse.

---
 rtl/xor_nn_sequencer.sv | 175 +++++++++++++++++
 tb/tb_xor_nn_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/xor_nn_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : xor_nn_sequencer
// Function : Time-shared MAC sequencer for the XOR network forward pass.
//            Hidden neurons then the output neuron share one MAC and one
//            external sigmoid; weights come from an external combinational ROM.
// Revision : 1.0  initial release
// ============================================================================
module xor_nn_sequencer #(
    parameter int N_HIDDEN = 3,
    parameter int ADDR_W   = 4,
    parameter int ACC_W    = 18,
    parameter int H_SHIFT  = 0,
    parameter int O_SHIFT  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        x,
    output logic              busy,
    output logic              done,
    output logic [7:0]        y_out,
    output logic              y_bit,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [7:0]        w_data,
    output logic [7:0]        sig_in,
    input  logic [7:0]        sig_out
);

    // Counter wide enough for the hidden MAC index (0..2) and output index (0..N).
    localparam int c_CW = (N_HIDDEN < 3) ? 2 : $clog2(N_HIDDEN + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_H_MAC = 3'd1,
        S_H_ACT = 3'd2,
        S_O_MAC = 3'd3,
        S_O_ACT = 3'd4
    } state_t;

    state_t            r_state, w_next;
    logic [c_CW-1:0]   r_j, r_k;
    logic [1:0]        r_x;
    logic [ACC_W-1:0]  r_acc, w_term, w_acc_next, w_h_sh, w_o_sh;
    logic [7:0]        r_a2 [N_HIDDEN];
    logic [7:0]        w_a2_sel, w_sat_h, w_sat_o, r_sig_in, r_y;
    logic              r_busy, r_done, w_last_j, w_k_out_last;
    logic [15:0]       w_prod;
    logic [ADDR_W-1:0] w_addr_c;

    assign w_last_j     = (r_j == c_CW'(N_HIDDEN - 1));
    assign w_k_out_last = (r_k == c_CW'(N_HIDDEN));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_addr_c = '0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_H_MAC;
            S_H_MAC: begin
                w_addr_c = ADDR_W'(3 * int'(r_j) + int'(r_k));
                if (r_k == c_CW'(2)) w_next = S_H_ACT;
            end
            S_H_ACT: w_next = w_last_j ? S_O_MAC : S_H_MAC;
            S_O_MAC: begin
                if (w_k_out_last) begin
                    w_addr_c = ADDR_W'(4 * N_HIDDEN);
                    w_next   = S_O_ACT;
                end else begin
                    w_addr_c = ADDR_W'(3 * N_HIDDEN + int'(r_k));
                end
            end
            S_O_ACT: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_a2_sel = '0;
        for (int i = 0; i < N_HIDDEN; i++)
            if (r_k == c_CW'(i)) w_a2_sel = r_a2[i];
    end

    assign w_prod = {8'b0, w_data} * {8'b0, w_a2_sel};

    // Hidden inputs are single bits, so each hidden term is the weight or zero.
    always_comb begin
        w_term = '0;
        if (r_state == S_H_MAC) begin
            case (r_k)
                c_CW'(0): w_term = r_x[0] ? ACC_W'(w_data) : '0;
                c_CW'(1): w_term = r_x[1] ? ACC_W'(w_data) : '0;
                default:  w_term = ACC_W'(w_data);
            endcase
        end else if (r_state == S_O_MAC) begin
            w_term = w_k_out_last ? ACC_W'(w_data) : ACC_W'(w_prod);
        end
    end

    assign w_acc_next = (r_k == '0) ? w_term : r_acc + w_term;
    assign w_h_sh     = w_acc_next >> H_SHIFT;
    assign w_o_sh     = w_acc_next >> O_SHIFT;
    assign w_sat_h    = (w_h_sh > ACC_W'(255)) ? 8'hFF : w_h_sh[7:0];
    assign w_sat_o    = (w_o_sh > ACC_W'(255)) ? 8'hFF : w_o_sh[7:0];

    // sig_in is registered on the last MAC edge so it is stable for the whole ACT cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_j      <= '0;
            r_k      <= '0;
            r_x      <= '0;
            r_acc    <= '0;
            r_sig_in <= '0;
            r_y      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < N_HIDDEN; i++) r_a2[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= x;
                        r_j    <= '0;
                        r_k    <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_H_MAC: begin
                    r_acc <= w_acc_next;
                    if (r_k == c_CW'(2)) begin
                        r_k      <= '0;
                        r_sig_in <= w_sat_h;
                    end else begin
                        r_k <= r_k + c_CW'(1);
                    end
                end
                S_H_ACT: begin
                    for (int i = 0; i < N_HIDDEN; i++)
                        if (r_j == c_CW'(i)) r_a2[i] <= sig_out;
                    r_j <= w_last_j ? '0 : r_j + c_CW'(1);
                end
                S_O_MAC: begin
                    r_acc <= w_acc_next;
                    if (w_k_out_last) begin
                        r_k      <= '0;
                        r_sig_in <= w_sat_o;
                    end else begin
                        r_k <= r_k + c_CW'(1);
                    end
                end
                S_O_ACT: begin
                    r_y    <= sig_out;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign y_out  = r_y;
    assign y_bit  = r_y[7];
    assign w_addr = w_addr_c;
    assign sig_in = r_sig_in;

endmodule
`default_nettype wire

// File: tb/tb_xor_nn_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xor_nn_sequencer
// Function : Self-checking bench for xor_nn_sequencer against a network model.
// Revision : 1.0  initial release
// ============================================================================
module tb_xor_nn_sequencer;

    logic       clock = 1'b0;
    logic       reset, start;
    logic [1:0] x;
    logic       busy, done, y_bit;
    logic [7:0] y_out, sig_in, sig_out, w_data;
    logic [3:0] w_addr;
    logic       busy_s, done_s, y_bit_s;
    logic [7:0] y_out_s, sig_in_s, sig_out_s, w_data_s;
    logic [3:0] w_addr_s;
    logic [7:0] rom [16];
    bit         sig_mode;
    int         total = 0;
    int         bad   = 0;

    xor_nn_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .x(x),
        .busy(busy), .done(done), .y_out(y_out), .y_bit(y_bit),
        .w_addr(w_addr), .w_data(w_data), .sig_in(sig_in), .sig_out(sig_out)
    );

    xor_nn_sequencer #(.O_SHIFT(0)) dut_sat (
        .clock(clock), .reset(reset), .start(start), .x(x),
        .busy(busy_s), .done(done_s), .y_out(y_out_s), .y_bit(y_bit_s),
        .w_addr(w_addr_s), .w_data(w_data_s), .sig_in(sig_in_s), .sig_out(sig_out_s)
    );

    assign w_data    = rom[w_addr];
    assign w_data_s  = rom[w_addr_s];
    assign sig_out   = sig_mode ? ((sig_in == 8'hFF) ? 8'hFF : sig_in + 8'd1) : sig_in;
    assign sig_out_s = sig_in_s;

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sigm(input int z, input bit mode);
        if (!mode) return z;
        return (z + 1 > 255) ? 255 : z + 1;
    endfunction

    // Forward pass of the 2-3-1 network straight from the ROM contents.
    function automatic int model_y(input logic [1:0] xv, input bit mode, input int osh);
        int acc, z;
        acc = int'(rom[12]);
        for (int j = 0; j < 3; j++) begin
            z = int'(rom[3*j]) * int'(xv[0]) + int'(rom[3*j+1]) * int'(xv[1]) + int'(rom[3*j+2]);
            if (z > 255) z = 255;
            acc += int'(rom[9+j]) * sigm(z, mode);
        end
        z = acc >> osh;
        if (z > 255) z = 255;
        return sigm(z, mode);
    endfunction

    task automatic load_default_rom();
        logic [7:0] v [13];
        v = '{47, 61, 23, 35, 46, 7, 55, 37, 13, 75, 44, 66, 33};
        for (int i = 0; i < 16; i++) rom[i] = (i < 13) ? v[i] : 8'd0;
    endtask

    // Called at a negedge with the DUT idle (or in its done cycle); returns at the
    // negedge of the done cycle.
    task automatic run(input logic [1:0] xv, input bit hold, input bit scramble, input bit check_addr);
        int exp_y, exp_s, bad_busy, k;
        int addrs [17];
        exp_y = model_y(xv, sig_mode, 8);
        exp_s = model_y(xv, 1'b0, 0);
        x     = xv;
        start = 1'b1;
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
        bad_busy = 0;
        for (int c = 0; c < 17; c++) begin
            addrs[c] = int'(w_addr);
            if (!busy || done || !busy_s || done_s) bad_busy++;
            if (scramble) begin
                x = 2'($urandom);
                if (!hold) start = 1'($urandom);
            end
            @(posedge clock); #1;
        end
        if (!hold) start = 1'b0;
        chk("busy_during_run", bad_busy, 0);
        chk("done_at_17", int'(done), 1);
        chk("busy_cleared", int'(busy), 0);
        chk("y_out", int'(y_out), exp_y);
        chk("y_bit", int'(y_bit), exp_y >> 7);
        chk("done_sat", int'(done_s), 1);
        chk("y_out_sat", int'(y_out_s), exp_s);
        if (check_addr) begin
            k = 0;
            for (int c = 0; c < 17; c++) begin
                if (!((c < 12 && c % 4 == 3) || c == 16)) begin
                    chk($sformatf("w_addr_%0d", k), addrs[c], k);
                    k++;
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic idle_hold(input int n);
        int held_y, errs;
        held_y = int'(y_out);
        errs   = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            if (done || busy || int'(y_out) != held_y) errs++;
        end
        chk("idle_hold", errs, 0);
        @(negedge clock);
    endtask

    initial begin
        int errs;
        reset    = 1'b1;
        start    = 1'b0;
        x        = 2'b00;
        sig_mode = 1'b0;
        load_default_rom();
        @(negedge clock); @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_y_out", int'(y_out), 0);
        chk("rst_y_bit", int'(y_bit), 0);
        chk("rst_w_addr", int'(w_addr), 0);
        chk("rst_sig_in", int'(sig_in), 0);
        reset = 1'b0;
        @(negedge clock);

        run(2'b11, 1'b0, 1'b0, 1'b1);
        chk("x11_literal", int'(y_out), 80);
        chk("x11_sat_literal", int'(y_out_s), 255);
        chk("x11_sat_bit", int'(y_bit_s), 1);
        idle_hold(3);
        run(2'b00, 1'b0, 1'b0, 1'b0);
        chk("x00_literal", int'(y_out), 11);
        idle_hold(2);
        run(2'b01, 1'b0, 1'b0, 1'b0);
        chk("x01_literal", int'(y_out), 45);
        idle_hold(2);

        // Offset sigmoid: result must follow sig_out rather than sig_in.
        sig_mode = 1'b1;
        run(2'b11, 1'b0, 1'b0, 1'b0);
        sig_mode = 1'b0;
        idle_hold(2);

        // start held high: back-to-back runs, x scrambled after each accept.
        for (int r = 0; r < 3; r++) run(2'($urandom), 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        idle_hold(2);

        // Asynchronous reset partway through a run.
        x     = 2'b11;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_y_out", int'(y_out), 0);
        chk("mid_rst_w_addr", int'(w_addr), 0);
        @(negedge clock);
        reset = 1'b0;
        errs  = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (done || busy) errs++;
        end
        chk("mid_rst_no_done", errs, 0);
        @(negedge clock);
        run(2'b11, 1'b0, 1'b0, 1'b0);
        idle_hold(1);

        // Randomized ROM contents, inputs, sigmoid model, gaps and mid-run noise.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 13; i++) rom[i] = 8'($urandom);
            sig_mode = 1'($urandom);
            run(2'($urandom), 1'b0, 1'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) idle_hold($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
